multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the 16-bit Unicycle datapath.
- Consumes the 32-bit one-hot opcode vector from the L_Control instruction decoder and steps the datapath through FETCH/DECODE/EXEC/MEM/WB.
- Generates register-file, SP, PC and memory strobes, and runs the memory request/acknowledge handshake.
- Sits between the instruction register/decoder and the shared datapath resources.

---
 rtl/ctrl_pkg.sv | 71 +++++++
 rtl/multicycle_ctrl_op_classifier.sv | 29 ++
 rtl/multicycle_ctrl.sv | 171 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle sequencer.
// Contents: FSM state enum, op_vec bit indices (OP_ADD=31 .. OP_GEQ=0),
// op-class group masks, wb_sel encodings and the op-class enum.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_SPOP,
    CLS_PCOP,
    CLS_BR,
    CLS_LD,
    CLS_ST
  } op_class_t;

  localparam int unsigned OP_ADD    = 31;
  localparam int unsigned OP_AND    = 30;
  localparam int unsigned OP_OR     = 29;
  localparam int unsigned OP_XOR    = 28;
  localparam int unsigned OP_SUB    = 27;
  localparam int unsigned OP_NAND   = 26;
  localparam int unsigned OP_NOR    = 25;
  localparam int unsigned OP_XNOR   = 24;
  localparam int unsigned OP_LU     = 23;
  localparam int unsigned OP_LL     = 22;
  localparam int unsigned OP_ADDI   = 21;
  localparam int unsigned OP_SHIFT  = 20;
  localparam int unsigned OP_RETURN = 19;
  localparam int unsigned OP_JUMP   = 18;
  localparam int unsigned OP_STRSP  = 17;
  localparam int unsigned OP_RTVSP  = 16;
  localparam int unsigned OP_STR    = 15;
  localparam int unsigned OP_RTV    = 14;
  localparam int unsigned OP_READ   = 13;
  localparam int unsigned OP_WRITE  = 12;
  localparam int unsigned OP_GETSP  = 11;
  localparam int unsigned OP_CHGSP  = 10;
  localparam int unsigned OP_SETSP  = 9;
  localparam int unsigned OP_GETPC  = 8;
  localparam int unsigned OP_CHGPC  = 7;
  localparam int unsigned OP_SETPC  = 6;
  localparam int unsigned OP_CHGSPI = 5;
  localparam int unsigned OP_CHGPCI = 4;
  localparam int unsigned OP_EQ     = 3;
  localparam int unsigned OP_LT     = 2;
  localparam int unsigned OP_NEQ    = 1;
  localparam int unsigned OP_GEQ    = 0;

  // Group masks over the 32-bit one-hot vector; together they cover every bit once.
  localparam logic [31:0] MASK_ALU  = 32'hFFF0_0000;  // ADD..SHIFT
  localparam logic [31:0] MASK_PCOP = 32'h000C_01D0;  // RETURN JUMP GETPC CHGPC SETPC CHGPCI
  localparam logic [31:0] MASK_SPOP = 32'h0000_0E20;  // GETSP CHGSP SETSP CHGSPI
  localparam logic [31:0] MASK_ST   = 32'h0002_9000;  // STRSP STR WRITE
  localparam logic [31:0] MASK_LD   = 32'h0001_6000;  // RTVSP RTV READ
  localparam logic [31:0] MASK_BR   = 32'h0000_000F;  // EQ LT NEQ GEQ

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_SP  = 2'b10;
  localparam logic [1:0] WB_PC  = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_op_classifier.sv
// op_classifier: combinational op-class decode of the one-hot opcode vector.
// Ports:
//   op_vec    in  [OPW-1:0]  decoder one-hot opcode vector
//   op_class  out op_class_t ALU/SPOP/PCOP/BR/LD/ST (meaningful only when onehot_ok)
//   onehot_ok out            exactly one bit of op_vec is set
module op_classifier
  import ctrl_pkg::*;
#(
  parameter int unsigned OPW = 32
) (
  input  logic [OPW-1:0] op_vec,
  output op_class_t      op_class,
  output logic           onehot_ok
);

  always_comb begin
    op_class = CLS_ALU;
    if      (|(op_vec & OPW'(MASK_ALU)))  op_class = CLS_ALU;
    else if (|(op_vec & OPW'(MASK_SPOP))) op_class = CLS_SPOP;
    else if (|(op_vec & OPW'(MASK_PCOP))) op_class = CLS_PCOP;
    else if (|(op_vec & OPW'(MASK_BR)))   op_class = CLS_BR;
    else if (|(op_vec & OPW'(MASK_LD)))   op_class = CLS_LD;
    else if (|(op_vec & OPW'(MASK_ST)))   op_class = CLS_ST;
  end

  // Nonzero with no second bit set.
  assign onehot_ok = (op_vec != '0) && ((op_vec & (op_vec - OPW'(1))) == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit Unicycle datapath.
// Optional macro CTRL_PERF_CNT_EN adds perf_retired/perf_stall counters.
// Ports:
//   clk, reset (sync, active-high)
//   op_vec [OPW-1:0] one-hot opcode, cond branch result, mem_ack memory done
//   mem_req/mem_we/addr_sel memory request, ir_load/pc_inc/pc_load IR and PC strobes,
//   reg_we/wb_sel[1:0]/sp_we register-file and SP writes,
//   illegal sticky fault flag, retired one-cycle pulse per completed instruction
//   perf_retired[31:0], perf_stall[31:0] (CTRL_PERF_CNT_EN only)
module multicycle_ctrl #(
  parameter int unsigned OPW      = 32,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op_vec,
  input  logic           cond,
  input  logic           mem_ack,
  output logic           mem_req,
  output logic           mem_we,
  output logic           addr_sel,
  output logic           ir_load,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           reg_we,
  output logic [1:0]     wb_sel,
  output logic           sp_we,
  output logic           illegal,
  output logic           retired
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]    perf_retired,
  output logic [31:0]    perf_stall
`endif
);
  import ctrl_pkg::*;

  state_t    state, nxt;
  op_class_t cls;
  logic      onehot_ok;
  logic      st_q;
  logic      illegal_q;
  logic      set_illegal;
  logic      timeout;
  logic [31:0] wait_cnt;

  op_classifier #(.OPW(OPW)) u_cls (
    .op_vec    (op_vec),
    .op_class  (cls),
    .onehot_ok (onehot_ok)
  );

  // True on the wait cycle that brings the count up to WAIT_MAX.
  assign timeout = (WAIT_MAX != 0) && (wait_cnt == WAIT_MAX - 32'd1);
  assign illegal = illegal_q;

  always_comb begin
    nxt         = state;
    set_illegal = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = WB_ALU;
    sp_we       = 1'b0;
    retired     = 1'b0;
    case (state)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          nxt     = S_DECODE;
        end else if (timeout) begin
          set_illegal = 1'b1;
          nxt         = S_HALT;
        end
      end
      S_DECODE: begin
        if (onehot_ok) begin
          nxt = S_EXEC;
        end else begin
          set_illegal = 1'b1;
          nxt         = S_HALT;
        end
      end
      S_EXEC: begin
        retired = 1'b1;
        nxt     = S_FETCH;
        case (cls)
          CLS_ALU: reg_we = 1'b1;
          CLS_SPOP: begin
            if (op_vec[OP_GETSP]) begin
              reg_we = 1'b1;
              wb_sel = WB_SP;
            end else begin
              sp_we = 1'b1;
            end
          end
          CLS_PCOP: begin
            if (op_vec[OP_GETPC]) begin
              reg_we = 1'b1;
              wb_sel = WB_PC;
            end else begin
              pc_load = 1'b1;
              sp_we   = op_vec[OP_RETURN];
            end
          end
          CLS_BR: pc_load = cond;
          default: begin
            retired = 1'b0;
            nxt     = S_MEM;
          end
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = st_q;
        if (mem_ack) begin
          retired = st_q;
          nxt     = st_q ? S_FETCH : S_WB;
        end else if (timeout) begin
          set_illegal = 1'b1;
          nxt         = S_HALT;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = WB_MEM;
        retired = 1'b1;
        nxt     = S_FETCH;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      st_q      <= 1'b0;
      illegal_q <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state <= nxt;
      if (set_illegal) illegal_q <= 1'b1;
      // Store/load is latched in EXEC so mem_we stays stable through MEM.
      if (state == S_EXEC) st_q <= (cls == CLS_ST);
      if (mem_req && !mem_ack && !timeout) wait_cnt <= wait_cnt + 32'd1;
      else                                 wait_cnt <= '0;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (retired)             perf_retired <= perf_retired + 32'd1;
      if (mem_req && !mem_ack) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (WAIT_MAX=4, default build).
// Each instruction is planned up front (opcode, wait counts, cond); the expected
// per-cycle output vector follows from the instruction-class rules.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int unsigned TB_WAIT = 4;

  // Expected-vector bit positions: {req,we,as,irl,pci,pcl,rwe,wb[1:0],spwe,ill,ret}
  localparam logic [11:0] E_REQ   = 12'h800;
  localparam logic [11:0] E_WE    = 12'h400;
  localparam logic [11:0] E_AS    = 12'h200;
  localparam logic [11:0] E_IRL   = 12'h100;
  localparam logic [11:0] E_PCI   = 12'h080;
  localparam logic [11:0] E_PCL   = 12'h040;
  localparam logic [11:0] E_RWE   = 12'h020;
  localparam logic [11:0] E_WBSP  = 12'h010;
  localparam logic [11:0] E_WBMEM = 12'h008;
  localparam logic [11:0] E_WBPC  = 12'h018;
  localparam logic [11:0] E_SPWE  = 12'h004;
  localparam logic [11:0] E_ILL   = 12'h002;
  localparam logic [11:0] E_RET   = 12'h001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] op_vec = '0;
  logic        cond = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, reg_we, sp_we, illegal, retired;
  logic [1:0]  wb_sel;
  logic [11:0] outs;
  op_class_t   probe_cls;
  logic        probe_ok;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned ret_seen = 0;
  int unsigned ret_exp = 0;

  multicycle_ctrl #(.OPW(32), .WAIT_MAX(TB_WAIT)) dut (
    .clk(clk), .reset(reset), .op_vec(op_vec), .cond(cond), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .reg_we(reg_we), .wb_sel(wb_sel),
    .sp_we(sp_we), .illegal(illegal), .retired(retired)
  );

  op_classifier #(.OPW(32)) u_probe (
    .op_vec(op_vec), .op_class(probe_cls), .onehot_ok(probe_ok)
  );

  assign outs = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, reg_we, wb_sel, sp_we, illegal, retired};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference classification straight from the opcode table.
  function automatic op_class_t cls_of(input int idx);
    if (idx >= 20) return CLS_ALU;
    case (idx)
      19, 18, 8, 7, 6, 4: return CLS_PCOP;
      11, 10, 9, 5:       return CLS_SPOP;
      17, 15, 12:         return CLS_ST;
      16, 14, 13:         return CLS_LD;
      default:            return CLS_BR;
    endcase
  endfunction

  function automatic logic [11:0] exec_exp(input int idx, input logic cnd);
    case (cls_of(idx))
      CLS_ALU:  return E_RWE | E_RET;
      CLS_SPOP: return (idx == 11) ? (E_RWE | E_WBSP | E_RET) : (E_SPWE | E_RET);
      CLS_PCOP: begin
        if (idx == 8)  return E_RWE | E_WBPC | E_RET;
        if (idx == 19) return E_PCL | E_SPWE | E_RET;
        return E_PCL | E_RET;
      end
      CLS_BR:   return (cnd ? E_PCL : 12'h000) | E_RET;
      default:  return 12'h000;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // mode 0: ack low, 1: ack high, 2: random
  function automatic logic ack_of(input int mode);
    if (mode == 2) return rbit();
    return (mode == 1);
  endfunction

  task automatic chk(input string nm, input longint unsigned got, input longint unsigned want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Entered at posedge+1; drives inputs, compares at negedge, returns at next posedge+1.
  task automatic tick(input logic ack, input logic cnd, input logic [11:0] exp, input string nm);
    mem_ack = ack;
    cond    = cnd;
    @(negedge clk);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d op=%h got=%b want=%b", nm, cyc, op_vec, outs, exp);
    end
    if (retired === 1'b1) ret_seen++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic halt_tail(input int n);
    repeat (n) tick(rbit(), rbit(), E_ILL, "halt");
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b1;
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    repeat (n - 1) tick(rbit(), rbit(), 12'h000, "reset_hold");
    reset = 1'b0;
    tick(rbit(), rbit(), 12'h000, "idle");
  endtask

  task automatic run_instr(input logic [31:0] op, input logic cnd, input int unsigned fw,
                           input int unsigned mw, input int amode, output logic halted);
    int idx;
    int ones;
    op_class_t c;
    logic [11:0] mexp;
    halted = 1'b0;
    op_vec = op;
    idx = 0;
    ones = 0;
    for (int i = 0; i < 32; i++) if (op[i]) begin idx = i; ones++; end
    if (fw >= TB_WAIT) begin
      repeat (TB_WAIT) tick(1'b0, rbit(), E_REQ, "fetch_wait");
      halt_tail(5);
      halted = 1'b1;
      return;
    end
    repeat (fw) tick(1'b0, rbit(), E_REQ, "fetch_wait");
    tick(1'b1, rbit(), E_REQ | E_IRL | E_PCI, "fetch_ack");
    tick(ack_of(amode), rbit(), 12'h000, "decode");
    chk("cls_onehot", longint'(probe_ok), longint'(ones == 1));
    if (ones != 1) begin
      halt_tail(5);
      halted = 1'b1;
      return;
    end
    c = cls_of(idx);
    chk("cls_class", longint'(probe_cls), longint'(c));
    tick(ack_of(amode), cnd, exec_exp(idx, cnd), "exec");
    if (c != CLS_ST && c != CLS_LD) begin
      ret_exp++;
      return;
    end
    mexp = E_REQ | E_AS | ((c == CLS_ST) ? E_WE : 12'h000);
    if (mw >= TB_WAIT) begin
      repeat (TB_WAIT) tick(1'b0, rbit(), mexp, "mem_wait");
      halt_tail(5);
      halted = 1'b1;
      return;
    end
    repeat (mw) tick(1'b0, rbit(), mexp, "mem_wait");
    tick(1'b1, rbit(), mexp | ((c == CLS_ST) ? E_RET : 12'h000), "mem_ack");
    if (c == CLS_LD) tick(ack_of(amode), rbit(), E_RWE | E_WBMEM | E_RET, "wb");
    ret_exp++;
  endtask

  initial begin
    logic h;
    int unsigned c0;
    logic [31:0] op;
    int unsigned fw, mw, r;

    do_reset(3);

    // ADD, ack tied high: 3 cycles
    c0 = cyc;
    run_instr(32'h8000_0000, 1'b0, 0, 0, 1, h);
    chk("lat_add", cyc - c0, 3);

    // RTV with 2 waits in FETCH and MEM: 9 cycles
    c0 = cyc;
    run_instr(32'h0000_4000, 1'b0, 2, 2, 0, h);
    chk("lat_rtv_waits", cyc - c0, 9);

    // EQ not taken, then taken
    run_instr(32'h0000_0008, 1'b0, 0, 0, 0, h);
    run_instr(32'h0000_0008, 1'b1, 1, 0, 0, h);

    // zero-wait store and load
    c0 = cyc;
    run_instr(32'h0000_8000, 1'b0, 0, 0, 0, h);
    chk("lat_store", cyc - c0, 4);
    c0 = cyc;
    run_instr(32'h0000_2000, 1'b0, 0, 0, 0, h);
    chk("lat_load", cyc - c0, 5);

    // RETURN, GETPC, GETSP, SETSP
    run_instr(32'h0008_0000, 1'b0, 0, 0, 2, h);
    run_instr(32'h0000_0100, 1'b0, 0, 0, 2, h);
    run_instr(32'h0000_0800, 1'b0, 0, 0, 2, h);
    run_instr(32'h0000_0200, 1'b0, 0, 0, 2, h);

    // illegal opcodes
    run_instr(32'h0000_0000, 1'b0, 0, 0, 0, h);
    chk("halt_zero", longint'(h), 1);
    chk("illegal_zero", longint'(illegal), 1);
    do_reset(1);
    run_instr(32'h0000_0003, 1'b0, 0, 0, 0, h);
    chk("illegal_two_bits", longint'(illegal), 1);
    do_reset(2);

    // wait limit boundary: 3 waits fine, 4 waits time out
    run_instr(32'h4000_0000, 1'b0, TB_WAIT - 1, 0, 0, h);
    run_instr(32'h0001_0000, 1'b0, 0, TB_WAIT - 1, 0, h);
    run_instr(32'h4000_0000, 1'b0, TB_WAIT, 0, 0, h);
    chk("timeout_fetch", longint'(illegal), 1);
    do_reset(1);
    run_instr(32'h0000_1000, 1'b0, 0, TB_WAIT, 0, h);
    chk("timeout_mem", longint'(illegal), 1);
    do_reset(1);

    // reset in the middle of a MEM store, late ack ignored
    op_vec = 32'h0000_8000;
    tick(1'b1, 1'b0, E_REQ | E_IRL | E_PCI, "r_fetch");
    tick(1'b0, 1'b0, 12'h000, "r_decode");
    tick(1'b0, 1'b0, 12'h000, "r_exec");
    tick(1'b0, 1'b0, E_REQ | E_AS | E_WE, "r_mem_wait");
    reset   = 1'b1;
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1'b1, 1'b0, 12'h000, "r_idle_late_ack");
    run_instr(32'h0010_0000, 1'b0, TB_WAIT - 1, 0, 0, h);

    // randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 88)      op = 32'h1 << $urandom_range(0, 31);
      else if (r < 92) op = 32'h0;
      else             op = $urandom;
      fw = ($urandom_range(0, 99) < 3) ? TB_WAIT : $urandom_range(0, TB_WAIT - 1);
      mw = ($urandom_range(0, 99) < 3) ? TB_WAIT : $urandom_range(0, TB_WAIT - 1);
      run_instr(op, rbit(), fw, mw, 2, h);
      if (h) do_reset(int'($urandom_range(1, 2)));
    end

    chk("retired_count", ret_seen, ret_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
